// File: rtl/cfs_md_rx_ctrl_skid_if.sv
// ---------------------------------------------------------------------------
// cfs_md_rx_ctrl_skid_if
//   Bundles the MD RX beat handshake and the RX FIFO push handshake used by
//   cfs_md_rx_ctrl_skid.
//
//   The parameters must match the ones given to the controller. The widths of
//   offset, size and push_data are derived from them in the same way.
//
//   Signals:
//     md_rx_valid / md_rx_data / md_rx_offset / md_rx_size
//       The MD beat, driven by the master.
//     md_rx_ready / md_rx_err
//       The controller's answer to that beat.
//     push_valid / push_data
//       Head of the skid buffer, presented to the RX FIFO.
//     push_ready
//       Driven by the RX FIFO side.
//
//   Modports:
//     master : the MD source and RX FIFO side (drives the beat and push_ready).
//     slave  : the controller.
// ---------------------------------------------------------------------------
interface cfs_md_rx_ctrl_skid_if #(
  parameter int ALGN_DATA_WIDTH = 32,
  parameter int FWD_ILLEGAL     = 0
);
  localparam int BYTES = ALGN_DATA_WIDTH / 8;
  localparam int OW    = (ALGN_DATA_WIDTH <= 8) ? 1 : $clog2(BYTES);
  localparam int SW    = $clog2(BYTES) + 1;
  localparam int PW    = ALGN_DATA_WIDTH + OW + SW + FWD_ILLEGAL;

  logic                       md_rx_valid;
  logic [ALGN_DATA_WIDTH-1:0] md_rx_data;
  logic [OW-1:0]              md_rx_offset;
  logic [SW-1:0]              md_rx_size;
  logic                       md_rx_ready;
  logic                       md_rx_err;

  logic                       push_valid;
  logic [PW-1:0]              push_data;
  logic                       push_ready;

  modport master (
    output md_rx_valid, md_rx_data, md_rx_offset, md_rx_size, push_ready,
    input  md_rx_ready, md_rx_err, push_valid, push_data
  );

  modport slave (
    input  md_rx_valid, md_rx_data, md_rx_offset, md_rx_size, push_ready,
    output md_rx_ready, md_rx_err, push_valid, push_data
  );
endinterface

// File: rtl/cfs_md_rx_ctrl_skid.sv
// ---------------------------------------------------------------------------
// cfs_md_rx_ctrl_skid
//   RX controller for the Aligner MD RX interface.
//
//   Function:
//     - Classifies each MD beat as legal or illegal.
//     - Keeps one saturating drop counter per error class (size and align).
//     - Stores legal beats in a 2-entry skid buffer in front of the RX FIFO.
//       Illegal beats are also stored, with an error flag, when FWD_ILLEGAL=1.
//     - push_data is read straight from the buffer registers. md_rx_ready
//       depends only on the buffer fill level and the beat's own legality.
//       So there is no combinational path from push_ready to md_rx_ready.
//
//   Clocking and reset:
//     Single clock (pclk). Asynchronous active-low reset (preset_n).
//
//   Ports:
//     pclk           clock
//     preset_n       asynchronous active-low reset
//     md             MD beat and push handshake (slave modport)
//     clr_cnt        synchronous clear of both drop counters
//     cnt_drop_size  saturating count of size-class drops
//     cnt_drop_align saturating count of align-class drops
//
//   Layout of push_data: {[err,] size, offset, data}.
//   The err MSB is present only when FWD_ILLEGAL=1.
// ---------------------------------------------------------------------------
module cfs_md_rx_ctrl_skid #(
  parameter int ALGN_DATA_WIDTH = 32,
  parameter int CNT_WIDTH       = 8,
  parameter int CHECK_BOUND     = 1,
  parameter int FWD_ILLEGAL     = 0
) (
  input  logic                     pclk,
  input  logic                     preset_n,
  cfs_md_rx_ctrl_skid_if.slave     md,
  input  logic                     clr_cnt,
  output logic [CNT_WIDTH-1:0]     cnt_drop_size,
  output logic [CNT_WIDTH-1:0]     cnt_drop_align
);

  localparam int BYTES = ALGN_DATA_WIDTH / 8;
  localparam int OW    = (ALGN_DATA_WIDTH <= 8) ? 1 : $clog2(BYTES);
  localparam int SW    = $clog2(BYTES) + 1;
  localparam int PW    = ALGN_DATA_WIDTH + OW + SW + FWD_ILLEGAL;
  // One extra bit so that BYTES+offset and offset+size cannot overflow.
  localparam int XW    = SW + 1;
  localparam int DEPTH = 2;

  localparam logic BOUND_EN = (CHECK_BOUND != 0);
  localparam logic FWD_EN   = (FWD_ILLEGAL != 0);

  // -------------------------------------------------------------------------
  // Legality classification (combinational)
  // -------------------------------------------------------------------------
  logic [XW-1:0] size_ext;
  logic [XW-1:0] off_ext;
  logic [XW-1:0] bytes_ext;
  logic [XW-1:0] base_sum;
  logic [XW-1:0] bound_sum;
  logic [XW-1:0] size_div;
  logic [XW-1:0] base_rem;
  logic          size_bad;
  logic          align_bad;
  logic          bound_bad;
  logic          beat_illegal;

  assign size_ext  = XW'(md.md_rx_size);
  assign off_ext   = XW'(md.md_rx_offset);
  assign bytes_ext = XW'(BYTES);
  assign base_sum  = bytes_ext + off_ext;
  assign bound_sum = off_ext + size_ext;

  assign size_bad  = (size_ext == '0) || (size_ext > bytes_ext);

  // A bad size would make the modulo meaningless, or a divide by zero.
  // The size rule has priority anyway, so substitute a harmless divisor.
  assign size_div  = size_bad ? XW'(1) : size_ext;
  assign base_rem  = base_sum % size_div;
  assign bound_bad = BOUND_EN && (bound_sum > bytes_ext);

  // The align class only applies when the size class did not already match.
  assign align_bad    = !size_bad && ((base_rem != '0) || bound_bad);
  assign beat_illegal = size_bad || align_bad;

  assign md.md_rx_err = md.md_rx_valid && beat_illegal;

  // -------------------------------------------------------------------------
  // Skid buffer control
  // -------------------------------------------------------------------------
  logic [1:0]    count_reg;
  logic [1:0]    count_next;
  logic          wr_ptr_reg;
  logic          rd_ptr_reg;
  logic          buf_full;
  logic          accept;
  logic          wr_en;
  logic          pop;
  logic [PW-1:0] wr_payload;
  logic [PW-1:0] entry_reg [DEPTH];

  assign buf_full = (count_reg == 2'd2);

  // When illegal beats are dropped they never occupy a slot.
  // They can therefore be consumed even while the buffer is full.
  assign md.md_rx_ready = !buf_full || (!FWD_EN && md.md_rx_err);

  assign accept = md.md_rx_valid && md.md_rx_ready;
  assign wr_en  = accept && (FWD_EN || !beat_illegal);
  assign pop    = md.push_valid && md.push_ready;

  generate
    if (FWD_ILLEGAL != 0) begin : g_payload_err
      assign wr_payload = {beat_illegal, md.md_rx_size, md.md_rx_offset, md.md_rx_data};
    end else begin : g_payload_plain
      assign wr_payload = {md.md_rx_size, md.md_rx_offset, md.md_rx_data};
    end
  endgenerate

  always_comb begin
    count_next = count_reg;
    if (wr_en && !pop) begin
      count_next = count_reg + 2'd1;
    end else if (!wr_en && pop) begin
      count_next = count_reg - 2'd1;
    end
  end

  always_ff @(posedge pclk or negedge preset_n) begin
    if (!preset_n) begin
      count_reg  <= 2'd0;
      wr_ptr_reg <= 1'b0;
      rd_ptr_reg <= 1'b0;
    end else begin
      count_reg <= count_next;
      if (wr_en) begin
        wr_ptr_reg <= !wr_ptr_reg;
      end
      if (pop) begin
        rd_ptr_reg <= !rd_ptr_reg;
      end
    end
  end

  // Payload storage needs no reset. An entry is only ever read after it has
  // been written, because push_valid is gated by count_reg.
  always_ff @(posedge pclk) begin
    if (wr_en) begin
      entry_reg[wr_ptr_reg] <= wr_payload;
    end
  end

  assign md.push_valid = (count_reg != 2'd0);
  assign md.push_data  = entry_reg[rd_ptr_reg];

  // -------------------------------------------------------------------------
  // Drop counters: index 0 is the size class, index 1 is the align class.
  // -------------------------------------------------------------------------
  logic [1:0]                inc_class;
  logic [1:0][CNT_WIDTH-1:0] cnt_vec;

  assign inc_class[0] = accept && size_bad;
  assign inc_class[1] = accept && align_bad;

  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_cnt
      logic [CNT_WIDTH-1:0] cnt_reg;

      // The clear takes priority, so a drop in the clearing cycle is lost.
      always_ff @(posedge pclk or negedge preset_n) begin
        if (!preset_n) begin
          cnt_reg <= '0;
        end else if (clr_cnt) begin
          cnt_reg <= '0;
        end else if (inc_class[gi] && !(&cnt_reg)) begin
          cnt_reg <= cnt_reg + CNT_WIDTH'(1);
        end
      end

      assign cnt_vec[gi] = cnt_reg;
    end
  endgenerate

  assign cnt_drop_size  = cnt_vec[0];
  assign cnt_drop_align = cnt_vec[1];

endmodule

// File: tb/tb_cfs_md_rx_ctrl_skid.sv
// ---------------------------------------------------------------------------
// tb_cfs_md_rx_ctrl_skid
//   Two controllers share one clock and one reset:
//     dut0 : FWD_ILLEGAL=0 (illegal beats are dropped)
//     dut1 : FWD_ILLEGAL=1 (illegal beats are forwarded with an err bit)
//
//   The reference model keeps, for each controller:
//     - a queue of beats still waiting to be pushed, and
//     - two integer drop counters.
//   Each cycle it classifies the beat with plain arithmetic and compares the
//   result with the design.
// ---------------------------------------------------------------------------
module tb_cfs_md_rx_ctrl_skid;

  localparam int DW = 32;

  logic pclk = 1'b0;
  logic preset_n;
  always #5 pclk = ~pclk;

  cfs_md_rx_ctrl_skid_if #(.ALGN_DATA_WIDTH(DW), .FWD_ILLEGAL(0)) md0 ();
  cfs_md_rx_ctrl_skid_if #(.ALGN_DATA_WIDTH(DW), .FWD_ILLEGAL(1)) md1 ();

  logic       clr0, clr1;
  logic [7:0] cs0, ca0, cs1, ca1;

  cfs_md_rx_ctrl_skid #(.ALGN_DATA_WIDTH(DW), .CNT_WIDTH(8), .CHECK_BOUND(1), .FWD_ILLEGAL(0)) dut0 (
    .pclk(pclk), .preset_n(preset_n), .md(md0), .clr_cnt(clr0),
    .cnt_drop_size(cs0), .cnt_drop_align(ca0)
  );

  cfs_md_rx_ctrl_skid #(.ALGN_DATA_WIDTH(DW), .CNT_WIDTH(8), .CHECK_BOUND(1), .FWD_ILLEGAL(1)) dut1 (
    .pclk(pclk), .preset_n(preset_n), .md(md1), .clr_cnt(clr1),
    .cnt_drop_size(cs1), .cnt_drop_align(ca1)
  );

  // Stimulus variables, one set per controller.
  bit          v   [2];
  logic [31:0] d   [2];
  logic [1:0]  off [2];
  logic [2:0]  sz  [2];
  bit          pr  [2];
  bit          clr [2];

  assign md0.md_rx_valid  = v[0];
  assign md0.md_rx_data   = d[0];
  assign md0.md_rx_offset = off[0];
  assign md0.md_rx_size   = sz[0];
  assign md0.push_ready   = pr[0];
  assign clr0             = clr[0];
  assign md1.md_rx_valid  = v[1];
  assign md1.md_rx_data   = d[1];
  assign md1.md_rx_offset = off[1];
  assign md1.md_rx_size   = sz[1];
  assign md1.push_ready   = pr[1];
  assign clr1             = clr[1];

  // Observed outputs, with push_data widened to a common width.
  logic        rdy [2];
  logic        err [2];
  logic        pv  [2];
  logic [37:0] pd  [2];
  logic [7:0]  cs  [2];
  logic [7:0]  ca  [2];

  assign rdy[0] = md0.md_rx_ready;
  assign err[0] = md0.md_rx_err;
  assign pv[0]  = md0.push_valid;
  assign pd[0]  = {1'b0, md0.push_data};
  assign cs[0]  = cs0;
  assign ca[0]  = ca0;
  assign rdy[1] = md1.md_rx_ready;
  assign err[1] = md1.md_rx_err;
  assign pv[1]  = md1.push_valid;
  assign pd[1]  = md1.push_data;
  assign cs[1]  = cs1;
  assign ca[1]  = ca1;

  int n_checks = 0;
  int n_pass   = 0;

  // Reference model state.
  logic [37:0] q0 [$];
  logic [37:0] q1 [$];
  int          mcs [2];
  int          mca [2];
  bit          last_acc [2];

  function automatic int qsize(int k);
    return (k == 0) ? q0.size() : q1.size();
  endfunction

  function automatic logic [37:0] qfront(int k);
    return (k == 0) ? q0[0] : q1[0];
  endfunction

  // Returns 0 for a legal beat, 1 for the size class, 2 for the align class.
  // Data width is 32, so BYTES = 4.
  function automatic int classify(logic [1:0] o, logic [2:0] s);
    int oi = int'(o);
    int si = int'(s);
    if (si == 0 || si > 4) return 1;
    if (((4 + oi) % si) != 0) return 2;
    if (oi + si > 4) return 2;
    return 0;
  endfunction

  task automatic model_reset();
    q0.delete();
    q1.delete();
    for (int k = 0; k < 2; k++) begin
      mcs[k]      = 0;
      mca[k]      = 0;
      last_acc[k] = 1'b0;
    end
  endtask

  task automatic drive(int k, bit vv, logic [31:0] dd, logic [1:0] oo, logic [2:0] ss);
    v[k]   = vv;
    d[k]   = dd;
    off[k] = oo;
    sz[k]  = ss;
  endtask

  // One clock cycle. This task is entered just after a rising edge.
  //   1. Checks the combinational answer (ready, err) against the model.
  //   2. Waits for the edge and advances the model.
  //   3. Checks the registered outputs against the model.
  task automatic cycle();
    int          cls [2];
    bit          e_err [2];
    bit          e_rdy [2];
    bit          acc [2];
    logic [37:0] ent;
    #1;
    for (int k = 0; k < 2; k++) begin
      cls[k]   = classify(off[k], sz[k]);
      e_err[k] = v[k] && (cls[k] != 0);
      e_rdy[k] = (qsize(k) != 2) || (k == 0 && e_err[k]);
      acc[k]   = v[k] && e_rdy[k];
      n_checks++;
      if (rdy[k] !== e_rdy[k]) $display("FAIL md_rx_ready dut%0d t=%0t: got %b expected %b", k, $time, rdy[k], e_rdy[k]);
      else n_pass++;
      n_checks++;
      if (err[k] !== e_err[k]) $display("FAIL md_rx_err dut%0d t=%0t: got %b expected %b", k, $time, err[k], e_err[k]);
      else n_pass++;
    end
    @(posedge pclk);
    for (int k = 0; k < 2; k++) begin
      last_acc[k] = acc[k];
      if (qsize(k) != 0 && pr[k]) begin
        if (k == 0) void'(q0.pop_front());
        else        void'(q1.pop_front());
      end
      if (acc[k] && (k == 1 || cls[k] == 0)) begin
        ent = {(k == 1) ? e_err[k] : 1'b0, sz[k], off[k], d[k]};
        if (k == 0) q0.push_back(ent);
        else        q1.push_back(ent);
      end
      if (clr[k]) begin
        mcs[k] = 0;
        mca[k] = 0;
      end else if (acc[k] && cls[k] == 1) begin
        mcs[k] = (mcs[k] < 255) ? mcs[k] + 1 : 255;
      end else if (acc[k] && cls[k] == 2) begin
        mca[k] = (mca[k] < 255) ? mca[k] + 1 : 255;
      end
    end
    #1;
    for (int k = 0; k < 2; k++) begin
      n_checks++;
      if (pv[k] !== (qsize(k) != 0)) $display("FAIL push_valid dut%0d t=%0t: got %b expected %b", k, $time, pv[k], (qsize(k) != 0));
      else n_pass++;
      if (qsize(k) != 0) begin
        n_checks++;
        if (pd[k] !== qfront(k)) $display("FAIL push_data dut%0d t=%0t: got %h expected %h", k, $time, pd[k], qfront(k));
        else n_pass++;
      end
      n_checks++;
      if (int'(cs[k]) != mcs[k]) $display("FAIL cnt_drop_size dut%0d t=%0t: got %0d expected %0d", k, $time, cs[k], mcs[k]);
      else n_pass++;
      n_checks++;
      if (int'(ca[k]) != mca[k]) $display("FAIL cnt_drop_align dut%0d t=%0t: got %0d expected %0d", k, $time, ca[k], mca[k]);
      else n_pass++;
    end
    $display("cycle t=%0t dut0 v=%0b off=%0d sz=%0d acc=%0b q=%0d | dut1 v=%0b off=%0d sz=%0d acc=%0b q=%0d",
             $time, v[0], off[0], sz[0], last_acc[0], qsize(0), v[1], off[1], sz[1], last_acc[1], qsize(1));
  endtask

  task automatic test_reset();
    preset_n = 1'b0;
    for (int k = 0; k < 2; k++) begin
      drive(k, 1'b0, 32'h0, 2'd0, 3'd0);
      pr[k]  = 1'b0;
      clr[k] = 1'b0;
    end
    model_reset();
    #3;
    for (int k = 0; k < 2; k++) begin
      n_checks++;
      if (pv[k] !== 1'b0 || cs[k] !== 8'd0 || ca[k] !== 8'd0 || rdy[k] !== 1'b1)
        $display("FAIL reset_state dut%0d: got pv=%b cs=%0d ca=%0d rdy=%b expected pv=0 cs=0 ca=0 rdy=1", k, pv[k], cs[k], ca[k], rdy[k]);
      else n_pass++;
    end
    #10 preset_n = 1'b1;
    @(posedge pclk);
    #1;
  endtask

  task automatic test_legal();
    pr[0] = 1'b1;
    drive(0, 1'b1, 32'hDEADBEEF, 2'd0, 3'd4);
    cycle();
    n_checks++;
    if (pv[0] !== 1'b1 || pd[0] !== {1'b0, 3'd4, 2'd0, 32'hDEADBEEF})
      $display("FAIL t1_push dut0: got pv=%b data=%h expected pv=1 data=%h", pv[0], pd[0], {1'b0, 3'd4, 2'd0, 32'hDEADBEEF});
    else n_pass++;
    n_checks++;
    if (cs[0] !== 8'd0 || ca[0] !== 8'd0) $display("FAIL t1_counters dut0: got %0d/%0d expected 0/0", cs[0], ca[0]);
    else n_pass++;
    drive(0, 1'b0, 32'h0, 2'd0, 3'd0);
    cycle();
  endtask

  task automatic test_illegal_classes();
    logic [1:0] t_off [4] = '{2'd0, 2'd0, 2'd1, 2'd2};
    logic [2:0] t_sz  [4] = '{3'd0, 3'd5, 3'd2, 3'd3};
    int         e_cs  [4] = '{1, 2, 2, 2};
    int         e_ca  [4] = '{0, 0, 1, 2};
    pr[0] = 1'b1;
    for (int i = 0; i < 4; i++) begin
      drive(0, 1'b1, $urandom, t_off[i], t_sz[i]);
      cycle();
      n_checks++;
      if (err[0] !== 1'b1 || pv[0] !== 1'b0 || int'(cs[0]) != e_cs[i] || int'(ca[0]) != e_ca[i])
        $display("FAIL t2_case%0d: got err=%b pv=%b cs=%0d ca=%0d expected err=1 pv=0 cs=%0d ca=%0d",
                 i, err[0], pv[0], cs[0], ca[0], e_cs[i], e_ca[i]);
      else n_pass++;
    end
    drive(0, 1'b0, 32'h0, 2'd0, 3'd0);
    cycle();
  endtask

  task automatic test_backpressure();
    logic [31:0] beats [3];
    logic [31:0] got [$];
    for (int i = 0; i < 3; i++) beats[i] = $urandom;
    pr[0] = 1'b0;
    for (int i = 0; i < 2; i++) begin
      drive(0, 1'b1, beats[i], 2'd0, 3'd4);
      cycle();
      n_checks++;
      if (last_acc[0] !== 1'b1) $display("FAIL t3_accept%0d: got 0 expected 1", i);
      else n_pass++;
    end
    drive(0, 1'b1, beats[2], 2'd0, 3'd4);
    for (int i = 0; i < 3; i++) cycle();
    n_checks++;
    if (rdy[0] !== 1'b0 || last_acc[0] !== 1'b0) $display("FAIL t3_held: got rdy=%b acc=%b expected 0/0", rdy[0], last_acc[0]);
    else n_pass++;
    drive(0, 1'b1, beats[2], 2'd0, 3'd0);
    cycle();
    n_checks++;
    if (rdy[0] !== 1'b1 || last_acc[0] !== 1'b1) $display("FAIL t3_illegal_when_full: got rdy=%b acc=%b expected 1/1", rdy[0], last_acc[0]);
    else n_pass++;
    drive(0, 1'b1, beats[2], 2'd0, 3'd4);
    pr[0] = 1'b1;
    for (int i = 0; i < 8; i++) begin
      if (pv[0] && pr[0]) got.push_back(pd[0][31:0]);
      cycle();
      if (last_acc[0]) v[0] = 1'b0;
    end
    n_checks++;
    if (got.size() != 3) $display("FAIL t3_pop_count: got %0d expected 3", got.size());
    else n_pass++;
    for (int i = 0; i < 3 && i < got.size(); i++) begin
      n_checks++;
      if (got[i] !== beats[i]) $display("FAIL t3_order%0d: got %h expected %h", i, got[i], beats[i]);
      else n_pass++;
    end
  endtask

  task automatic test_random(int k, int n);
    int    r;
    int    sel;
    bit [2:0] s;
    for (int i = 0; i < n; i++) begin
      r = $urandom_range(0, 99);
      sel = $urandom_range(0, 3);
      s = (sel == 0) ? 3'($urandom_range(0, 7)) : (sel == 1) ? 3'd1 : (sel == 2) ? 3'd2 : 3'd4;
      drive(k, r < 80, $urandom, 2'($urandom_range(0, 3)), s);
      pr[k]  = ($urandom_range(0, 99) < 65);
      clr[k] = ($urandom_range(0, 99) < 3);
      cycle();
    end
    clr[k] = 1'b0;
    drive(k, 1'b0, 32'h0, 2'd0, 3'd0);
    pr[k] = 1'b1;
    for (int i = 0; i < 3; i++) cycle();
  endtask

  task automatic test_saturation();
    drive(0, 1'b0, 32'h0, 2'd0, 3'd0);
    clr[0] = 1'b1;
    pr[0]  = 1'b1;
    cycle();
    clr[0] = 1'b0;
    for (int i = 0; i < 260; i++) begin
      drive(0, 1'b1, $urandom, 2'($urandom_range(0, 3)), 3'd0);
      cycle();
    end
    n_checks++;
    if (cs[0] !== 8'd255) $display("FAIL t4_saturate: got %0d expected 255", cs[0]);
    else n_pass++;
    clr[0] = 1'b1;
    cycle();
    n_checks++;
    if (cs[0] !== 8'd0 || ca[0] !== 8'd0) $display("FAIL t4_clear_wins: got %0d/%0d expected 0/0", cs[0], ca[0]);
    else n_pass++;
    clr[0] = 1'b0;
    drive(0, 1'b0, 32'h0, 2'd0, 3'd0);
    cycle();
  endtask

  task automatic test_fwd_illegal();
    logic [31:0] dd;
    dd = $urandom;
    pr[1] = 1'b0;
    drive(1, 1'b1, dd, 2'd1, 3'd2);
    cycle();
    n_checks++;
    if (pv[1] !== 1'b1 || pd[1] !== {1'b1, 3'd2, 2'd1, dd} || ca[1] !== 8'd1)
      $display("FAIL t5_forward: got pv=%b data=%h ca=%0d expected pv=1 data=%h ca=1", pv[1], pd[1], ca[1], {1'b1, 3'd2, 2'd1, dd});
    else n_pass++;
    drive(1, 1'b1, $urandom, 2'd0, 3'd4);
    cycle();
    drive(1, 1'b1, $urandom, 2'd0, 3'd0);
    cycle();
    n_checks++;
    if (rdy[1] !== 1'b0 || last_acc[1] !== 1'b0 || cs[1] !== 8'd0)
      $display("FAIL t5_full_blocks_illegal: got rdy=%b acc=%b cs=%0d expected 0/0/0", rdy[1], last_acc[1], cs[1]);
    else n_pass++;
    pr[1] = 1'b1;
    test_random(1, 300);
  endtask

  task automatic test_reset_midop();
    pr[0] = 1'b0;
    drive(0, 1'b1, $urandom, 2'd0, 3'd4);
    cycle();
    drive(0, 1'b1, $urandom, 2'd0, 3'd2);
    cycle();
    drive(0, 1'b1, $urandom, 2'd1, 3'd2);
    cycle();
    drive(0, 1'b0, 32'h0, 2'd0, 3'd0);
    #2 preset_n = 1'b0;
    #1;
    model_reset();
    n_checks++;
    if (pv[0] !== 1'b0 || cs[0] !== 8'd0 || ca[0] !== 8'd0)
      $display("FAIL t6_async_reset: got pv=%b cs=%0d ca=%0d expected 0/0/0", pv[0], cs[0], ca[0]);
    else n_pass++;
    #3 preset_n = 1'b1;
    @(posedge pclk);
    #1;
    n_checks++;
    if (rdy[0] !== 1'b1 || pv[0] !== 1'b0) $display("FAIL t6_after_release: got rdy=%b pv=%b expected 1/0", rdy[0], pv[0]);
    else n_pass++;
    pr[0] = 1'b1;
    cycle();
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_legal();
    test_illegal_classes();
    test_backpressure();
    test_random(0, 400);
    test_saturation();
    test_fwd_illegal();
    test_reset_midop();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
